thumb_addsub_issue: RTL and testbench

Two-stage issue/writeback front end for the Cortex-M0 ALU datapath. It accepts 16-bit Thumb-1 add/subtract/move/compare instructions through a valid/ready handshake. It decodes each one, reads the low register file (r0–r7), and drives the ALU's `operand1`/`operand2`/`alu_control` from an execute register. On the following edge it captures the ALU's combinational `result`, writes it back, and updates the NZCV flags.

---
 rtl/thumb_addsub_issue.sv | 256 +++++++++++++++++++++++++
 tb/tb_thumb_addsub_issue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_addsub_issue.sv
// Two-stage Thumb-1 add/sub/mov/cmp issue front end: DEC reads r0-r7 (with
// bypass from EX) into execute registers that drive an external ALU; EX writes back.
`timescale 1ns/1ps

module thumb_addsub_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        stall,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [1:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic [3:0]  flags_nzcv,
    output logic        retired,
    output logic        undef,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] CTRL_ADD = 2'b00;
    localparam logic [1:0] CTRL_SUB = 2'b01;

    // ------------------------------------------------------------------
    // Reset release synchroniser
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_reg;
    logic       accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign instr_ready = rst_sync_reg[1] & ~stall;
    assign accept      = instr_valid & instr_ready;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       dec_supported;
    logic       dec_op1_zero;
    logic       dec_op2_imm;
    logic       dec_sub;
    logic       dec_we;
    logic       dec_set_nz;
    logic       dec_set_cv;
    logic [2:0] dec_ra;
    logic [2:0] dec_rb;
    logic [2:0] dec_rd;
    logic [7:0] dec_imm;

    always_comb begin
        dec_supported = 1'b0;
        dec_op1_zero  = 1'b0;
        dec_op2_imm   = 1'b0;
        dec_sub       = 1'b0;
        dec_we        = 1'b0;
        dec_set_nz    = 1'b0;
        dec_set_cv    = 1'b0;
        dec_ra        = 3'd0;
        dec_rb        = 3'd0;
        dec_rd        = 3'd0;
        dec_imm       = 8'd0;
        case (instr[15:11])
            5'b00011: begin
                // three-register and imm3 forms; bit 10 picks imm3, bit 9 picks SUB
                dec_supported = 1'b1;
                dec_ra        = instr[5:3];
                dec_rb        = instr[8:6];
                dec_rd        = instr[2:0];
                dec_op2_imm   = instr[10];
                dec_imm       = {5'd0, instr[8:6]};
                dec_sub       = instr[9];
                dec_we        = 1'b1;
                dec_set_nz    = 1'b1;
                dec_set_cv    = 1'b1;
            end
            5'b00100: begin
                dec_supported = 1'b1;
                dec_op1_zero  = 1'b1;
                dec_op2_imm   = 1'b1;
                dec_imm       = instr[7:0];
                dec_rd        = instr[10:8];
                dec_we        = 1'b1;
                dec_set_nz    = 1'b1;
            end
            5'b00101: begin
                dec_supported = 1'b1;
                dec_ra        = instr[10:8];
                dec_op2_imm   = 1'b1;
                dec_imm       = instr[7:0];
                dec_sub       = 1'b1;
                dec_set_nz    = 1'b1;
                dec_set_cv    = 1'b1;
            end
            5'b00110, 5'b00111: begin
                dec_supported = 1'b1;
                dec_ra        = instr[10:8];
                dec_rd        = instr[10:8];
                dec_op2_imm   = 1'b1;
                dec_imm       = instr[7:0];
                dec_sub       = instr[11];
                dec_we        = 1'b1;
                dec_set_nz    = 1'b1;
                dec_set_cv    = 1'b1;
            end
            default: begin
                dec_supported = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file and execute registers
    // ------------------------------------------------------------------
    logic [7:0][31:0] rf_word;
    logic             ex_valid_reg;
    logic             ex_we_reg;
    logic             ex_set_nz_reg;
    logic             ex_set_cv_reg;
    logic [31:0]      ex_op1_reg;
    logic [31:0]      ex_op2_reg;
    logic [1:0]       ex_ctrl_reg;
    logic [2:0]       ex_rd_reg;
    logic             undef_reg;
    logic [3:0]       flags_reg;
    logic             wb_en;

    assign wb_en = ex_valid_reg & ex_we_reg & ~stall;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rf
            logic [31:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= 32'd0;
                end else if (wb_en && (ex_rd_reg == 3'(gi))) begin
                    q_reg <= alu_result;
                end
            end
            assign rf_word[gi] = q_reg;
        end
    endgenerate

    // Bypass: the result leaving EX this cycle is newer than the register file.
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;

    assign fwd_a   = ex_valid_reg & ex_we_reg & (ex_rd_reg == dec_ra);
    assign fwd_b   = ex_valid_reg & ex_we_reg & (ex_rd_reg == dec_rb);
    assign src_a   = fwd_a ? alu_result : rf_word[dec_ra];
    assign src_b   = fwd_b ? alu_result : rf_word[dec_rb];
    assign dec_op1 = dec_op1_zero ? 32'd0 : src_a;
    assign dec_op2 = dec_op2_imm ? {24'd0, dec_imm} : src_b;

    // Empty EX slots hold zeros so the ALU sees 0 + 0 with ADD when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg  <= 1'b0;
            ex_we_reg     <= 1'b0;
            ex_set_nz_reg <= 1'b0;
            ex_set_cv_reg <= 1'b0;
            ex_op1_reg    <= 32'd0;
            ex_op2_reg    <= 32'd0;
            ex_ctrl_reg   <= CTRL_ADD;
            ex_rd_reg     <= 3'd0;
            undef_reg     <= 1'b0;
        end else begin
            undef_reg <= accept & ~dec_supported;
            if (!stall) begin
                if (accept && dec_supported) begin
                    ex_valid_reg  <= 1'b1;
                    ex_we_reg     <= dec_we;
                    ex_set_nz_reg <= dec_set_nz;
                    ex_set_cv_reg <= dec_set_cv;
                    ex_op1_reg    <= dec_op1;
                    ex_op2_reg    <= dec_op2;
                    ex_ctrl_reg   <= dec_sub ? CTRL_SUB : CTRL_ADD;
                    ex_rd_reg     <= dec_rd;
                end else begin
                    ex_valid_reg  <= 1'b0;
                    ex_we_reg     <= 1'b0;
                    ex_set_nz_reg <= 1'b0;
                    ex_set_cv_reg <= 1'b0;
                    ex_op1_reg    <= 32'd0;
                    ex_op2_reg    <= 32'd0;
                    ex_ctrl_reg   <= CTRL_ADD;
                    ex_rd_reg     <= 3'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    logic        ex_is_sub;
    logic [31:0] ex_sum;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    assign ex_is_sub = (ex_ctrl_reg == CTRL_SUB);
    assign ex_sum    = ex_op1_reg + ex_op2_reg;
    assign flag_n    = alu_result[31];
    assign flag_z    = (alu_result == 32'd0);

    // Unsigned wrap of the 32-bit sum is exactly the 33rd-bit carry.
    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (ex_is_sub) begin
            flag_c = (ex_op1_reg >= ex_op2_reg);
            flag_v = (ex_op1_reg[31] != ex_op2_reg[31]) & (alu_result[31] != ex_op1_reg[31]);
        end else begin
            flag_c = (ex_sum < ex_op1_reg);
            flag_v = (ex_op1_reg[31] == ex_op2_reg[31]) & (alu_result[31] != ex_op1_reg[31]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 4'b0000;
        end else if (ex_valid_reg && !stall) begin
            if (ex_set_nz_reg) begin
                flags_reg[3] <= flag_n;
                flags_reg[2] <= flag_z;
            end
            if (ex_set_cv_reg) begin
                flags_reg[1] <= flag_c;
                flags_reg[0] <= flag_v;
            end
        end
    end

    assign alu_op1    = ex_op1_reg;
    assign alu_op2    = ex_op2_reg;
    assign alu_ctrl   = ex_ctrl_reg;
    assign flags_nzcv = flags_reg;
    assign retired    = ex_valid_reg & ~stall;
    assign undef      = undef_reg;
    assign dbg_data   = rf_word[dbg_addr];

endmodule

// File: tb/tb_thumb_addsub_issue.sv
// Bench for thumb_addsub_issue: directed scenarios plus random streams, scored
// against an architectural (one-instruction-at-a-time) model of r0-r7 and NZCV.
`timescale 1ns/1ps

module tb_thumb_addsub_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic        stall = 1'b0;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  flags_nzcv;
    logic        retired;
    logic        undef;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    thumb_addsub_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .stall       (stall),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .flags_nzcv  (flags_nzcv),
        .retired     (retired),
        .undef       (undef),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Combinational ALU standing in for the real datapath.
    assign alu_result = (alu_ctrl == 2'b01) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

    always #5 clk = ~clk;

    // Architectural model state: updated as soon as an instruction is accepted.
    logic [31:0] m_regs [8];
    logic [3:0]  m_flags = 4'b0000;
    int          m_sync = 0;
    logic        m_ex_valid = 1'b0;
    logic        m_undef = 1'b0;
    logic [31:0] m_op1 = 32'd0;
    logic [31:0] m_op2 = 32'd0;
    logic [1:0]  m_ctrl = 2'b00;

    logic        md_acc, md_ok, md_sub, md_we, md_nz, md_cv, md_c, md_v;
    logic [2:0]  md_rd;
    logic [31:0] md_a, md_b, md_r;
    logic [15:0] md_ins;
    longint      md_sv;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
            m_flags = 4'b0000; m_sync = 0; m_ex_valid = 1'b0; m_undef = 1'b0;
            m_op1 = 32'd0; m_op2 = 32'd0; m_ctrl = 2'b00;
        end else begin
            md_acc = instr_valid && (m_sync == 2) && !stall;
            m_undef = 1'b0;
            if (!stall) begin
                m_ex_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_ctrl = 2'b00;
            end
            if (md_acc) begin
                md_ins = instr;
                md_ok = 1'b1; md_sub = 1'b0; md_we = 1'b1; md_nz = 1'b1; md_cv = 1'b1;
                md_a = 32'd0; md_b = {24'd0, md_ins[7:0]}; md_rd = md_ins[10:8];
                case (md_ins[15:11])
                    5'b00011: begin
                        md_a   = m_regs[md_ins[5:3]];
                        md_b   = md_ins[10] ? {29'd0, md_ins[8:6]} : m_regs[md_ins[8:6]];
                        md_sub = md_ins[9];
                        md_rd  = md_ins[2:0];
                    end
                    5'b00100: md_cv = 1'b0;
                    5'b00101: begin md_a = m_regs[md_ins[10:8]]; md_sub = 1'b1; md_we = 1'b0; end
                    5'b00110: md_a = m_regs[md_ins[10:8]];
                    5'b00111: begin md_a = m_regs[md_ins[10:8]]; md_sub = 1'b1; end
                    default:  md_ok = 1'b0;
                endcase
                if (md_ok) begin
                    if (md_sub) begin
                        md_r  = md_a - md_b;
                        md_c  = (md_a >= md_b);
                        md_sv = longint'($signed(md_a)) - longint'($signed(md_b));
                    end else begin
                        md_r  = md_a + md_b;
                        md_c  = (({32'd0, md_a} + {32'd0, md_b}) > 64'hFFFF_FFFF);
                        md_sv = longint'($signed(md_a)) + longint'($signed(md_b));
                    end
                    md_v = (md_sv > 64'sd2147483647) || (md_sv < -64'sd2147483648);
                    if (md_we) m_regs[md_rd] = md_r;
                    if (md_nz) m_flags[3:2] = {md_r[31], md_r == 32'd0};
                    if (md_cv) m_flags[1:0] = {md_c, md_v};
                    m_ex_valid = 1'b1; m_op1 = md_a; m_op2 = md_b; m_ctrl = md_sub ? 2'b01 : 2'b00;
                    $display("[%0t] issue %04h op1=%08h op2=%08h r=%08h nzcv=%04b", $time, md_ins, md_a, md_b, md_r, m_flags);
                end else begin
                    m_undef = 1'b1;
                    $display("[%0t] issue %04h undefined", $time, md_ins);
                end
            end
            if (m_sync < 2) m_sync++;
        end
        #1;
        n_vec += 6;
        if (instr_ready !== ((m_sync == 2) && !stall)) begin n_err++; $display("FAIL mon_ready @%0t: got %b want %b", $time, instr_ready, (m_sync == 2) && !stall); end
        if (retired !== (m_ex_valid && !stall)) begin n_err++; $display("FAIL mon_retired @%0t: got %b want %b", $time, retired, m_ex_valid && !stall); end
        if (undef !== m_undef) begin n_err++; $display("FAIL mon_undef @%0t: got %b want %b", $time, undef, m_undef); end
        if (alu_op1 !== m_op1) begin n_err++; $display("FAIL mon_op1 @%0t: got %08h want %08h", $time, alu_op1, m_op1); end
        if (alu_op2 !== m_op2) begin n_err++; $display("FAIL mon_op2 @%0t: got %08h want %08h", $time, alu_op2, m_op2); end
        if (alu_ctrl !== m_ctrl) begin n_err++; $display("FAIL mon_ctrl @%0t: got %b want %b", $time, alu_ctrl, m_ctrl); end
    end

    task automatic drive(input logic v, input logic [15:0] ins, input logic st);
        @(negedge clk);
        instr_valid = v;
        instr       = ins;
        stall       = st;
    endtask

    task automatic drain();
        repeat (3) drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_vec += 6;
        if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin n_err++; $display("FAIL reset_ops: got %08h/%08h want 0/0", alu_op1, alu_op2); end
        if (alu_ctrl !== 2'b00) begin n_err++; $display("FAIL reset_ctrl: got %b want 00", alu_ctrl); end
        if (flags_nzcv !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags_nzcv); end
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
        if (retired !== 1'b0 || undef !== 1'b0) begin n_err++; $display("FAIL reset_ret_undef: got %b%b want 00", retired, undef); end
        if (dbg_data !== 32'd0) begin n_err++; $display("FAIL reset_dbg: got %08h want 0", dbg_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL ready_edge1: got %b want 0", instr_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ready_edge2: got %b want 1", instr_ready); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h21FF, 1'b0);              // MOVS r1,#0xFF
        drive(1'b1, 16'h2201, 1'b0);              // MOVS r2,#1
        #1; n_vec++;
        if (retired !== 1'b1) begin n_err++; $display("FAIL b2b_retired1: got %b want 1", retired); end
        drive(1'b1, 16'h188B, 1'b0);              // ADDS r3,r1,r2
        #1; n_vec++;
        if (retired !== 1'b1) begin n_err++; $display("FAIL b2b_retired2: got %b want 1", retired); end
        drive(1'b0, 16'h0000, 1'b0);
        #1; n_vec++;
        if (retired !== 1'b1) begin n_err++; $display("FAIL b2b_retired3: got %b want 1", retired); end
        drain();
        dbg_addr = 3'd3; #1; n_vec += 2;
        if (dbg_data !== 32'h0000_0100) begin n_err++; $display("FAIL b2b_r3: got %08h want 00000100", dbg_data); end
        if (flags_nzcv !== 4'b0000) begin n_err++; $display("FAIL b2b_flags: got %b want 0000", flags_nzcv); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1; n_vec++;
            if (dbg_data !== m_regs[i]) begin n_err++; $display("FAIL b2b_reg r%0d: got %08h want %08h", i, dbg_data, m_regs[i]); end
        end
    endtask

    task automatic test_carry_borrow();
        drive(1'b1, 16'h2000, 1'b0);              // MOVS r0,#0
        drive(1'b1, 16'h3801, 1'b0);              // SUBS r0,#1
        drain();
        dbg_addr = 3'd0; #1; n_vec += 2;
        if (dbg_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL borrow_r0: got %08h want ffffffff", dbg_data); end
        if (flags_nzcv !== 4'b1000) begin n_err++; $display("FAIL borrow_flags: got %b want 1000", flags_nzcv); end
        drive(1'b1, 16'h3001, 1'b0);              // ADDS r0,#1
        drain();
        #1; n_vec += 2;
        if (dbg_data !== 32'd0) begin n_err++; $display("FAIL carry_r0: got %08h want 0", dbg_data); end
        if (flags_nzcv !== 4'b0110) begin n_err++; $display("FAIL carry_flags: got %b want 0110", flags_nzcv); end
    endtask

    task automatic test_overflow();
        drive(1'b1, 16'h2401, 1'b0);              // MOVS r4,#1
        repeat (30) drive(1'b1, 16'h1924, 1'b0);  // ADDS r4,r4,r4
        drive(1'b1, 16'h1E65, 1'b0);              // SUBS r5,r4,#1
        drive(1'b1, 16'h1964, 1'b0);              // ADDS r4,r4,r5 -> 0x7FFFFFFF
        drain();
        dbg_addr = 3'd4; #1; n_vec++;
        if (dbg_data !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_build: got %08h want 7fffffff", dbg_data); end
        drive(1'b1, 16'h3401, 1'b0);              // ADDS r4,#1
        drain();
        #1; n_vec += 2;
        if (dbg_data !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_r4: got %08h want 80000000", dbg_data); end
        if (flags_nzcv !== 4'b1001) begin n_err++; $display("FAIL ovf_flags: got %b want 1001", flags_nzcv); end
    endtask

    task automatic test_cmp();
        drive(1'b1, 16'h2505, 1'b0);              // MOVS r5,#5
        drive(1'b1, 16'h2D05, 1'b0);              // CMP r5,#5
        drain();
        dbg_addr = 3'd5; #1; n_vec += 2;
        if (dbg_data !== 32'd5) begin n_err++; $display("FAIL cmp_r5: got %08h want 5", dbg_data); end
        if (flags_nzcv !== 4'b0110) begin n_err++; $display("FAIL cmp_flags: got %b want 0110", flags_nzcv); end
        drive(1'b1, 16'h2600, 1'b0);              // MOVS r6,#0
        drain();
        #1; n_vec++;
        if (flags_nzcv !== 4'b0110) begin n_err++; $display("FAIL movs_keeps_cv: got %b want 0110", flags_nzcv); end
    endtask

    task automatic test_undef();
        logic [3:0] saved;
        saved = m_flags;
        drive(1'b1, 16'hBF00, 1'b0);
        drive(1'b1, 16'h275A, 1'b0);              // MOVS r7,#0x5A straight after
        #1; n_vec += 3;
        if (undef !== 1'b1) begin n_err++; $display("FAIL undef_pulse: got %b want 1", undef); end
        if (retired !== 1'b0) begin n_err++; $display("FAIL undef_retired: got %b want 0", retired); end
        if (flags_nzcv !== saved) begin n_err++; $display("FAIL undef_flags: got %b want %b", flags_nzcv, saved); end
        drive(1'b0, 16'h0000, 1'b0);
        #1; n_vec += 2;
        if (undef !== 1'b0) begin n_err++; $display("FAIL undef_once: got %b want 0", undef); end
        if (retired !== 1'b1) begin n_err++; $display("FAIL undef_next: got %b want 1", retired); end
        drain();
        dbg_addr = 3'd7; #1; n_vec++;
        if (dbg_data !== 32'h0000_005A) begin n_err++; $display("FAIL undef_r7: got %08h want 0000005a", dbg_data); end
    endtask

    task automatic test_stall();
        logic [31:0] old3;
        logic [31:0] src1;
        old3 = m_regs[3];
        src1 = m_regs[1];
        drive(1'b1, 16'h185B, 1'b0);              // ADDS r3,r3,r1
        drive(1'b1, 16'h2703, 1'b1);              // stall with MOVS r7,#3 offered
        dbg_addr = 3'd3;
        #1; n_vec += 2;
        if (alu_op1 !== old3 || alu_op2 !== src1) begin n_err++; $display("FAIL stall_ops: got %08h/%08h want %08h/%08h", alu_op1, alu_op2, old3, src1); end
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", instr_ready); end
        repeat (3) begin
            @(posedge clk); #1; n_vec += 3;
            if (alu_op1 !== old3 || alu_op2 !== src1) begin n_err++; $display("FAIL stall_hold: got %08h/%08h want %08h/%08h", alu_op1, alu_op2, old3, src1); end
            if (dbg_data !== old3) begin n_err++; $display("FAIL stall_no_wb: got %08h want %08h", dbg_data, old3); end
            if (retired !== 1'b0) begin n_err++; $display("FAIL stall_retired: got %b want 0", retired); end
        end
        drive(1'b1, 16'h2703, 1'b0);
        @(posedge clk); #1; n_vec++;
        if (dbg_data !== old3 + src1) begin n_err++; $display("FAIL stall_wb: got %08h want %08h", dbg_data, old3 + src1); end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [15:0] ins;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case (r[31:29])
                3'd0, 3'd1, 3'd2: ins = {5'b00011, r[10:0]};
                3'd3, 3'd4, 3'd5: ins = {3'b001, r[12:0]};
                3'd6:             ins = r[15:0];
                default:          ins = 16'hBF00;
            endcase
            if (n == 200) begin
                @(negedge clk);
                rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0;
                #1; n_vec += 4;
                if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_ctrl !== 2'b00) begin n_err++; $display("FAIL midreset_alu: got %08h/%08h/%b want 0", alu_op1, alu_op2, alu_ctrl); end
                if (flags_nzcv !== 4'b0000) begin n_err++; $display("FAIL midreset_flags: got %b want 0000", flags_nzcv); end
                if (retired !== 1'b0 || undef !== 1'b0 || instr_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ctl: got %b%b%b want 000", retired, undef, instr_ready); end
                if (dbg_data !== 32'd0) begin n_err++; $display("FAIL midreset_dbg: got %08h want 0", dbg_data); end
                @(negedge clk);
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 4) == 0);
        end
        drain();
        n_vec++;
        if (flags_nzcv !== m_flags) begin n_err++; $display("FAIL rand_flags: got %b want %b", flags_nzcv, m_flags); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1; n_vec++;
            if (dbg_data !== m_regs[i]) begin n_err++; $display("FAIL rand_reg r%0d: got %08h want %08h", i, dbg_data, m_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_carry_borrow();
        test_overflow();
        test_cmp();
        test_undef();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
